pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 83 ++++++++
 tb/tb_pipe_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Hazard/stall/redirect control for a 4-stage in-order pipe; enables and flush are zero-latency.
// Priority redirect > multi-cycle EX stall > load-use hazard; stall_cnt saturates at all-ones.
module pipe_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ifu_vld,
  output logic                   if_rdy,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_busy,
  input  logic                   br_taken,
  output logic                   if_id_ld_en,
  output logic                   id_ex_ld_en,
  output logic                   ex_wb_ld_en,
  output logic                   id_vld,
  output logic                   ex_vld,
  output logic                   wb_vld,
  output logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic                   r_id_vld;
  logic                   r_ex_vld;
  logic                   r_wb_vld;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_ex_stall;
  logic w_hazard;
  logic w_redirect;
  logic w_rs1_match;
  logic w_rs2_match;
  logic w_cnt_max;

  assign w_ex_stall  = r_ex_vld & ex_busy;
  assign w_rs1_match = id_uses_rs1 & (id_rs1 == ex_rd);
  assign w_rs2_match = id_uses_rs2 & (id_rs2 == ex_rd);
  // x0 is never written, so a load targeting it cannot create a dependency
  assign w_hazard    = r_id_vld & r_ex_vld & ex_is_load & (ex_rd != 5'd0) &
                       (w_rs1_match | w_rs2_match);
  assign w_redirect  = r_ex_vld & br_taken & ~ex_busy;
  assign w_cnt_max   = &r_stall_cnt;

  assign if_rdy      = ~w_redirect & ~w_ex_stall & ~w_hazard;
  assign if_id_ld_en = w_redirect | (~w_ex_stall & ~w_hazard);
  assign id_ex_ld_en = ~w_ex_stall;
  assign ex_wb_ld_en = ~w_ex_stall;
  assign flush       = w_redirect;

  assign id_vld      = r_id_vld;
  assign ex_vld      = r_ex_vld;
  assign wb_vld      = r_wb_vld;
  assign stall_cnt   = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_vld    <= 1'b0;
      r_ex_vld    <= 1'b0;
      r_wb_vld    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      // A stall cycle drains EX into nothing, leaving a bubble in WB
      r_wb_vld <= r_ex_vld & ~w_ex_stall;

      if (!w_ex_stall) begin
        if (w_redirect || w_hazard) r_ex_vld <= 1'b0;
        else                        r_ex_vld <= r_id_vld;
      end

      if (w_redirect)                    r_id_vld <= 1'b0;
      else if (!w_ex_stall && !w_hazard) r_id_vld <= ifu_vld;

      if ((w_ex_stall || w_hazard) && !w_cnt_max)
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against an instruction-slot model.
module tb_pipe_ctrl;
  localparam int SCW = 4;
  localparam int CMAX = (1 << SCW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic ifu_vld, id_uses_rs1, id_uses_rs2, ex_is_load, ex_busy, br_taken;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic if_rdy, if_id_ld_en, id_ex_ld_en, ex_wb_ld_en, id_vld, ex_vld, wb_vld, flush;
  logic [SCW-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model: each stage holds an instruction tag, 0 meaning empty
  int m_id, m_ex, m_wb, m_cnt, m_tag;

  pipe_ctrl #(.STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst_n(rst_n), .ifu_vld(ifu_vld), .if_rdy(if_rdy),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_busy(ex_busy), .br_taken(br_taken), .if_id_ld_en(if_id_ld_en),
    .id_ex_ld_en(id_ex_ld_en), .ex_wb_ld_en(ex_wb_ld_en), .id_vld(id_vld),
    .ex_vld(ex_vld), .wb_vld(wb_vld), .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [7+SCW:0] w_obs;
  assign w_obs = {if_rdy, if_id_ld_en, id_ex_ld_en, ex_wb_ld_en, flush,
                  id_vld, ex_vld, wb_vld, stall_cnt};

  function automatic bit m_stall();
    return (m_ex != 0) && ex_busy;
  endfunction

  function automatic bit m_hazard();
    bit dep;
    dep = (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
    return (m_id != 0) && (m_ex != 0) && ex_is_load && (ex_rd != 0) && dep;
  endfunction

  function automatic bit m_redir();
    return (m_ex != 0) && br_taken && !ex_busy;
  endfunction

  function automatic logic [7+SCW:0] exp_vec();
    bit st, hz, rd;
    logic [SCW-1:0] c;
    st = m_stall();
    hz = m_hazard();
    rd = m_redir();
    c = m_cnt[SCW-1:0];
    return {!(rd || st || hz), rd || !(st || hz), !st, !st, rd,
            m_id != 0, m_ex != 0, m_wb != 0, c};
  endfunction

  task automatic model_clear();
    m_id = 0; m_ex = 0; m_wb = 0; m_cnt = 0;
  endtask

  // One clock: model advances on the same edge as the DUT, then return to the falling edge
  task automatic tick();
    bit st, hz, rd;
    @(posedge clk);
    st = m_stall(); hz = m_hazard(); rd = m_redir();
    if (!rst_n) model_clear();
    else begin
      if ((st || hz) && m_cnt < CMAX) m_cnt++;
      if (rd) begin
        m_wb = m_ex; m_ex = 0; m_id = 0;
      end else if (st) begin
        m_wb = 0;
      end else if (hz) begin
        m_wb = m_ex; m_ex = 0;
      end else begin
        m_wb = m_ex; m_ex = m_id;
        if (ifu_vld) begin m_tag++; m_id = m_tag; end
        else m_id = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifu_vld = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_is_load = 0; ex_rd = 0; ex_busy = 0; br_taken = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    model_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    logic [7+SCW:0] want;
    want = {5'b11110, 3'b000, {SCW{1'b0}}};
    rst_n = 0;
    idle_inputs();
    ifu_vld = 1; ex_busy = 1; br_taken = 1;
    model_clear();
    @(negedge clk);
    #1;
    n_vec++;
    if (w_obs !== want) begin
      n_err++; $display("FAIL reset_outputs: got %h want %h", w_obs, want);
    end
    tick();
    n_vec++;
    if (w_obs !== want) begin
      n_err++; $display("FAIL reset_held: got %h want %h", w_obs, want);
    end
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_free_flow();
    logic [SCW+2:0] want;
    apply_reset();
    ifu_vld = 1;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) ifu_vld = 0;
      #1;
      want = {c >= 1, c >= 2, c >= 3, {SCW{1'b0}}};
      n_vec++;
      if ({id_vld, ex_vld, wb_vld, stall_cnt} !== want) begin
        n_err++; $display("FAIL free_flow cyc %0d: got %h want %h", c,
                          {id_vld, ex_vld, wb_vld, stall_cnt}, want);
      end
      n_vec++;
      if ({if_id_ld_en, id_ex_ld_en, ex_wb_ld_en, if_rdy, flush} !== 5'b11110) begin
        n_err++; $display("FAIL free_flow_en cyc %0d: got %b want 11110", c,
                          {if_id_ld_en, id_ex_ld_en, ex_wb_ld_en, if_rdy, flush});
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    ifu_vld = 1;
    tick(); tick();
    ex_is_load = 1; ex_rd = 5; id_uses_rs1 = 1; id_rs1 = 5;
    #1;
    n_vec++;
    if ({if_rdy, if_id_ld_en, id_ex_ld_en, ex_wb_ld_en, w_obs} !== {4'b0011, exp_vec()}) begin
      n_err++; $display("FAIL load_use_bubble: got %b/%h want 0011/%h",
                        {if_rdy, if_id_ld_en, id_ex_ld_en, ex_wb_ld_en}, w_obs, exp_vec());
    end
    tick();
    ex_is_load = 0;
    #1;
    n_vec++;
    if ({id_vld, ex_vld, wb_vld, stall_cnt, if_rdy} !== {3'b101, SCW'(1), 1'b1}) begin
      n_err++; $display("FAIL load_use_after: got %b %0d want 101 1", {id_vld, ex_vld, wb_vld},
                        stall_cnt);
    end
    tick();
    n_vec++;
    if ({ex_vld, stall_cnt} !== {1'b1, SCW'(1)} || w_obs !== exp_vec()) begin
      n_err++; $display("FAIL load_use_enter: got ex=%b cnt=%0d want ex=1 cnt=1", ex_vld,
                        stall_cnt);
    end
  endtask

  task automatic test_load_x0();
    apply_reset();
    ifu_vld = 1;
    tick(); tick();
    ex_is_load = 1; ex_rd = 0; id_uses_rs1 = 1; id_rs1 = 0;
    #1;
    n_vec++;
    if ({if_rdy, if_id_ld_en} !== 2'b11 || w_obs !== exp_vec()) begin
      n_err++; $display("FAIL load_x0: got rdy/ld %b want 11", {if_rdy, if_id_ld_en});
    end
    tick();
    n_vec++;
    if ({ex_vld, stall_cnt} !== {1'b1, SCW'(0)}) begin
      n_err++; $display("FAIL load_x0_cnt: got ex=%b cnt=%0d want ex=1 cnt=0", ex_vld, stall_cnt);
    end
  endtask

  task automatic test_multicycle();
    apply_reset();
    ifu_vld = 1;
    tick(); tick(); tick();
    ex_busy = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if ({id_ex_ld_en, ex_wb_ld_en, ex_vld} !== 3'b001 || w_obs !== exp_vec()) begin
        n_err++; $display("FAIL busy_en cyc %0d: got %b/%h want 001/%h", c,
                          {id_ex_ld_en, ex_wb_ld_en, ex_vld}, w_obs, exp_vec());
      end
      tick();
      n_vec++;
      if ({wb_vld, ex_vld} !== 2'b01) begin
        n_err++; $display("FAIL busy_bubble cyc %0d: got wb/ex %b want 01", c, {wb_vld, ex_vld});
      end
    end
    ex_busy = 0;
    #1;
    n_vec++;
    if (stall_cnt !== SCW'(3)) begin
      n_err++; $display("FAIL busy_cnt: got %0d want 3", stall_cnt);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    ifu_vld = 1;
    tick(); tick();
    ex_busy = 1; br_taken = 1;
    #1;
    n_vec++;
    if (flush !== 1'b0 || w_obs !== exp_vec()) begin
      n_err++; $display("FAIL branch_busy: got flush %b want 0", flush);
    end
    tick();
    ex_busy = 0;
    #1;
    n_vec++;
    if ({flush, if_rdy, if_id_ld_en} !== 3'b101 || w_obs !== exp_vec()) begin
      n_err++; $display("FAIL branch_flush: got %b want 101", {flush, if_rdy, if_id_ld_en});
    end
    tick();
    br_taken = 0;
    n_vec++;
    if ({id_vld, ex_vld, wb_vld} !== 3'b001) begin
      n_err++; $display("FAIL branch_squash: got %b want 001", {id_vld, ex_vld, wb_vld});
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      ifu_vld     = ($urandom_range(0, 3) != 0);
      id_uses_rs1 = $urandom_range(0, 1);
      id_uses_rs2 = $urandom_range(0, 1);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_is_load  = ($urandom_range(0, 2) == 0);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_busy     = ($urandom_range(0, 4) == 0);
      br_taken    = ($urandom_range(0, 5) == 0);
      #1;
      n_vec++;
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL random cyc %0d: got %h want %h", c, w_obs, exp_vec());
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_saturation_reset();
    apply_reset();
    ifu_vld = 1;
    tick(); tick();
    ex_busy = 1;
    for (int c = 0; c < 20; c++) begin
      #1;
      n_vec++;
      if (w_obs !== exp_vec()) begin
        n_err++; $display("FAIL sat cyc %0d: got %h want %h", c, w_obs, exp_vec());
      end
      tick();
    end
    #1;
    n_vec++;
    if (stall_cnt !== SCW'(15)) begin
      n_err++; $display("FAIL sat_value: got %0d want 15", stall_cnt);
    end
    rst_n = 0;
    model_clear();
    #1;
    n_vec++;
    if ({id_vld, ex_vld, wb_vld, stall_cnt} !== '0 || w_obs !== exp_vec()) begin
      n_err++; $display("FAIL async_reset: got %b cnt %0d want 000 cnt 0",
                        {id_vld, ex_vld, wb_vld}, stall_cnt);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    ifu_vld = 1;
    tick();
    n_vec++;
    if ({id_vld, ex_vld, stall_cnt} !== {2'b10, SCW'(0)}) begin
      n_err++; $display("FAIL first_fetch: got id/ex %b cnt %0d want 10 cnt 0",
                        {id_vld, ex_vld}, stall_cnt);
    end
  endtask

  initial begin
    m_tag = 0;
    model_clear();
    test_reset();
    test_free_flow();
    test_load_use();
    test_load_x0();
    test_multicycle();
    test_branch();
    test_random();
    test_saturation_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
